mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified single-port data/instruction memory between the IF stage and the MEM stage.
- MEM request is derived from the EX/MEM outputs: m_req = mem_to_reg_m | mem_write_m, m_addr = alu_result_m, m_wdata = rdata2_m.
- Runs a req/ready/rvalid handshake to memory and drives per-stage stall signals so the pipeline holds until its access completes.
- Default priority goes to MEM (the older instruction), with a starvation bound for IF.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_MAX, 4, consecutive MEM grants allowed while if_req is pending before IF is forced to win (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched word, held until the next IF completion
- m_req  in  1  MEM stage access request, held until m_done
- m_we  in  1  1 = store, 0 = load
- m_addr  in  ADDR_W  load/store address
- m_wdata  in  DATA_W  store data
- m_done  out  1  one-cycle pulse: access complete
- m_rdata  out  DATA_W  load data, held until the next MEM read completion
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_m  out  1  m_req & ~m_done (combinational)
- mem_valid  out  1  request to memory
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data

Behaviour:
- FSM states:
  - IDLE: arbitrate. On any request, register owner, we, addr, wdata and go to ISSUE.
  - ISSUE: mem_valid=1 with the registered fields. On mem_ready, a read goes to WAIT_R and a write goes to RESP.
  - WAIT_R: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP: assert the owner's done for exactly one cycle, then go to IDLE.
- mem_valid, mem_we, mem_addr and mem_wdata are registered. They are stable throughout ISSUE and 0 outside ISSUE.
- Latency, with ready/rvalid returned immediately and the request seen in IDLE at cycle 0:
  - read: ISSUE at cycle 1, WAIT_R at cycle 2, done at cycle 3.
  - write: ISSUE at cycle 1, done at cycle 2.
- Arbitration in IDLE:
  - Only one request: it wins.
  - Both requesting: MEM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt:
  - Increments on each MEM grant while if_req=1, saturating at STARVE_MAX.
  - Clears on an IF grant, and on any MEM grant with if_req=0.
- In the RESP cycle the done requester's req still belongs to the completed instruction. Arbitration happens only in IDLE, so the next access is evaluated one cycle later. There is no double-issue.
- Request fields are latched at grant. Changes to addr/wdata/we or a dropped req mid-transaction do not alter the transaction; it completes normally, and the done pulse is still issued.
- mem_rvalid outside WAIT_R is ignored. mem_ready outside ISSUE is ignored.
- Reset (synchronous, rst=1 at the edge), from any state including mid-transaction:
  - state IDLE; starve_cnt 0.
  - mem_valid/mem_we/mem_addr/mem_wdata 0.
  - if_done/m_done 0; if_rdata/m_rdata 0.
  - An abandoned transaction's late mem_rvalid is ignored.
- stall outputs are combinational from req and done. They evaluate to 0 during reset only if the reqs are 0; no gating by rst is required.

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT_R=2'd2, RESP=2'd3.
  - owner constants: OWN_IF=1'b0, OWN_MEM=1'b1.
- Single module. A sub-module is not warranted; the starvation counter is inline.

Test Plan:
- Lone load: m_req=1, m_we=0, m_addr=16'h0040; memory returns ready at once and rvalid one cycle later with 16'hBEEF -> m_done pulses at cycle 3, m_rdata=16'hBEEF, stall_m=1 for cycles 0-2, mem_valid high only at cycle 1.
- Lone store: m_we=1, m_addr=16'h0010, m_wdata=16'h1234, ready held low 2 cycles -> mem_valid/addr/wdata stable 3 cycles, m_done at cycle 4.
- Contention: if_req and m_req both asserted at cycle 0 -> MEM served first, IF granted in the IDLE immediately after the MEM RESP, if_done correct, stall_if high throughout.
- Starvation, STARVE_MAX=4: if_req held, m_req re-asserted each IDLE -> exactly 4 MEM completions, then the 5th grant goes to IF, and starve_cnt returns to 0.
- Reset mid-read: rst in WAIT_R, then mem_rvalid=1 with 16'hDEAD -> no done pulse, m_rdata stays 0, state IDLE, mem_valid=0.
- Spurious handshakes: mem_rvalid/mem_ready pulsed while IDLE with no requests -> no output change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and the
// identifiers of the two requesting pipeline stages.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one single-port memory,
// MEM-first with a starvation bound for IF, and generates per-stage stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                m_req,
    input  logic                m_we,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [DATA_W-1:0]   m_wdata,
    output logic                m_done,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                stall_if,
    output logic                stall_m,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                grant_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            m_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

    // IF only wins contention once MEM has used up its run of consecutive grants.
    assign grant_if = if_req & (~m_req | (starve_q == STARVE_LIM));

    // Memory-side fields are latched at grant and held only while in ISSUE.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_rdata_d  = if_rdata_q;
        m_rdata_d   = m_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_IF;
                    starve_d    = '0;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = if_addr;
                end else if (m_req) begin
                    state_d     = ISSUE;
                    owner_d     = OWN_MEM;
                    starve_d    = !if_req ? '0 :
                                  (starve_q < STARVE_LIM) ? starve_q + 1'b1 : starve_q;
                    mem_valid_d = 1'b1;
                    mem_we_d    = m_we;
                    mem_addr_d  = m_addr;
                    mem_wdata_d = m_wdata;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = mem_we_q ? RESP : WAIT_R;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
                    else                   m_rdata_d  = mem_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if_done = (state_q == RESP) && (owner_q == OWN_IF);
        m_done  = (state_q == RESP) && (owner_q == OWN_MEM);
    end

    assign stall_if       = if_req & ~if_done;
    assign stall_m        = m_req & ~m_done;
    assign mem_valid      = mem_valid_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign if_rdata       = if_rdata_q;
    assign m_rdata        = m_rdata_q;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, latching, contention,
// starvation bound, mid-transaction reset and spurious handshakes.
module tb_mem_port_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_R = 2'd2, S_RESP = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, m_req, m_we, mem_ready, mem_rvalid;
    logic [15:0] if_addr, m_addr, m_wdata, mem_rdata;
    logic        if_done, m_done, stall_if, stall_m, mem_valid, mem_we;
    logic [15:0] if_rdata, m_rdata, mem_addr, mem_wdata;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_starve_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata),
        .stall_if(stall_if), .stall_m(stall_m),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; m_req = 0; m_we = 0; mem_ready = 0; mem_rvalid = 0;
        if_addr = '0; m_addr = '0; m_wdata = '0; mem_rdata = '0;
        step(); step();
        check("rst_state", dbg_state, S_IDLE);
        check("rst_valid", mem_valid, 0);
        check("rst_stall", {stall_if, stall_m}, 0);
        rst = 1'b0;
        step();
        check("rst_rdata", {if_rdata, m_rdata}, 0);
        check("rst_starve", dbg_starve_cnt, 0);
        check("rst_addr", mem_addr, 0);

        // Lone load
        m_req = 1; m_we = 0; m_addr = 16'h0040; mem_ready = 1; #1;
        check("ld_c0_stall_m", stall_m, 1);
        check("ld_c0_valid", mem_valid, 0);
        step();
        check("ld_c1_state", dbg_state, S_ISSUE);
        check("ld_c1_valid", mem_valid, 1);
        check("ld_c1_addr", mem_addr, 16'h0040);
        check("ld_c1_we", mem_we, 0);
        check("ld_c1_stall_m", stall_m, 1);
        step();
        mem_rvalid = 1; mem_rdata = 16'hBEEF; #1;
        check("ld_c2_state", dbg_state, S_WAIT_R);
        check("ld_c2_valid", mem_valid, 0);
        check("ld_c2_stall_m", stall_m, 1);
        check("ld_c2_done", m_done, 0);
        step();
        mem_rvalid = 0; #1;
        check("ld_c3_done", m_done, 1);
        check("ld_c3_rdata", m_rdata, 16'hBEEF);
        check("ld_c3_stall_m", stall_m, 0);
        check("ld_c3_if_done", if_done, 0);
        step();
        m_req = 0; #1;
        check("ld_c4_done", m_done, 0);
        check("ld_c4_state", dbg_state, S_IDLE);
        check("ld_c4_rdata_held", m_rdata, 16'hBEEF);

        // Lone store with ready held low two cycles; inputs change mid-flight
        m_req = 1; m_we = 1; m_addr = 16'h0010; m_wdata = 16'h1234; mem_ready = 0; #1;
        step();
        for (int i = 1; i <= 3; i++) begin
            m_addr = 16'hFFFF; m_wdata = 16'h0000;
            if (i == 3) mem_ready = 1;
            #1;
            check("st_valid", mem_valid, 1);
            check("st_addr", mem_addr, 16'h0010);
            check("st_wdata", mem_wdata, 16'h1234);
            check("st_we", mem_we, 1);
            check("st_no_done", m_done, 0);
            step();
        end
        mem_ready = 0; #1;
        check("st_c4_done", m_done, 1);
        check("st_c4_valid", mem_valid, 0);
        check("st_c4_stall_m", stall_m, 0);
        step();
        m_req = 0; m_we = 0; #1;
        check("st_c5_state", dbg_state, S_IDLE);
        check("st_c5_rdata", m_rdata, 16'hBEEF);

        // Contention: MEM first, then IF
        if_req = 1; if_addr = 16'h0100; m_req = 1; m_we = 0; m_addr = 16'h0200;
        mem_ready = 1; mem_rvalid = 0; #1;
        check("ct_c0_stall_if", stall_if, 1);
        step();
        check("ct_c1_addr", mem_addr, 16'h0200);
        check("ct_c1_stall_if", stall_if, 1);
        step();
        mem_rvalid = 1; mem_rdata = 16'h5555; #1;
        check("ct_c2_stall_if", stall_if, 1);
        step();
        mem_rvalid = 0; #1;
        check("ct_c3_m_done", m_done, 1);
        check("ct_c3_if_done", if_done, 0);
        check("ct_c3_m_rdata", m_rdata, 16'h5555);
        check("ct_c3_stall_if", stall_if, 1);
        step();
        m_req = 0; #1;
        check("ct_c4_state", dbg_state, S_IDLE);
        check("ct_c4_stall_if", stall_if, 1);
        step();
        check("ct_c5_state", dbg_state, S_ISSUE);
        check("ct_c5_addr", mem_addr, 16'h0100);
        check("ct_c5_stall_if", stall_if, 1);
        step();
        mem_rvalid = 1; mem_rdata = 16'h7777; #1;
        check("ct_c6_stall_if", stall_if, 1);
        step();
        mem_rvalid = 0; #1;
        check("ct_c7_if_done", if_done, 1);
        check("ct_c7_if_rdata", if_rdata, 16'h7777);
        check("ct_c7_m_rdata", m_rdata, 16'h5555);
        check("ct_c7_stall_if", stall_if, 0);
        step();
        if_req = 0; #1;
        check("ct_c8_if_done", if_done, 0);

        // Starvation: four MEM stores win, fifth grant goes to IF
        if_req = 1; if_addr = 16'h0300; m_req = 1; m_we = 1; m_wdata = 16'h00AA;
        mem_ready = 1; mem_rvalid = 0;
        for (int k = 0; k < 4; k++) begin
            m_addr = 16'(k); #1;
            check("sv_idle", dbg_state, S_IDLE);
            step();
            check("sv_mem_grant_addr", mem_addr, 32'(k));
            check("sv_mem_grant_we", mem_we, 1);
            check("sv_starve_cnt", dbg_starve_cnt, 32'(k + 1));
            step();
            check("sv_m_done", m_done, 1);
            check("sv_if_wait", {if_done, stall_if}, 2'b01);
            step();
        end
        m_addr = 16'h0044; #1;
        check("sv_starve_sat", dbg_starve_cnt, 4);
        step();
        check("sv_if_grant_addr", mem_addr, 16'h0300);
        check("sv_if_grant_we", mem_we, 0);
        check("sv_starve_clear", dbg_starve_cnt, 0);
        step();
        mem_rvalid = 1; mem_rdata = 16'h9999; #1;
        step();
        mem_rvalid = 0; #1;
        check("sv_if_done", if_done, 1);
        check("sv_if_rdata", if_rdata, 16'h9999);
        check("sv_m_not_done", m_done, 0);
        if_req = 0; m_req = 0; m_we = 0;
        step();
        check("sv_end_state", dbg_state, S_IDLE);

        // Reset in WAIT_R, then a late rvalid
        if_req = 1; if_addr = 16'h0500; m_req = 1; m_we = 0; m_addr = 16'h0050;
        mem_ready = 1; mem_rvalid = 0; #1;
        step();
        check("rr_c1_starve", dbg_starve_cnt, 1);
        step();
        check("rr_c2_state", dbg_state, S_WAIT_R);
        rst = 1;
        step();
        rst = 0; if_req = 0; m_req = 0; mem_rvalid = 1; mem_rdata = 16'hDEAD; #1;
        check("rr_c3_state", dbg_state, S_IDLE);
        check("rr_c3_done", {if_done, m_done}, 0);
        check("rr_c3_rdata", {if_rdata, m_rdata}, 0);
        check("rr_c3_valid", mem_valid, 0);
        check("rr_c3_starve", dbg_starve_cnt, 0);
        step();
        mem_rvalid = 0; #1;
        check("rr_c4_done", {if_done, m_done}, 0);
        check("rr_c4_m_rdata", m_rdata, 0);
        check("rr_c4_state", dbg_state, S_IDLE);

        // Spurious handshakes while idle
        mem_ready = 1; mem_rvalid = 1; mem_rdata = 16'hAAAA; #1;
        step();
        check("sp_c1_state", dbg_state, S_IDLE);
        check("sp_c1_valid", mem_valid, 0);
        check("sp_c1_done", {if_done, m_done}, 0);
        check("sp_c1_rdata", {if_rdata, m_rdata}, 0);
        step();
        mem_ready = 0; mem_rvalid = 0; #1;
        check("sp_c2_state", dbg_state, S_IDLE);
        check("sp_c2_rdata", {if_rdata, m_rdata}, 0);
        check("sp_c2_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
